// File: rtl/spi_host_wr_master_pkg.sv
// rtl/spi_host_wr_master_pkg.sv - shared types and helpers for the host write master
package spi_host_wr_master_pkg;

  localparam int SPI_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLAIM,
    ST_LOAD,
    ST_SETUP,
    ST_HIGH,
    ST_END,
    ST_RELEASE
  } state_t;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_host_wr_master_if.sv
// rtl/spi_host_wr_master_if.sv - local word stream plus chip-side bus signals
interface spi_host_wr_master_if #(
  parameter int SPI_WIDTH = spi_host_wr_master_pkg::SPI_WIDTH_DEF
) ();

  logic                 s_valid;
  logic [SPI_WIDTH-1:0] s_data;
  logic                 s_last;
  logic                 s_ready;
  logic                 near_full;
  logic                 oe_req;
  logic                 spi_cs_n;
  logic                 spi_sck;
  logic [SPI_WIDTH-1:0] spi_data_o;
  logic                 spi_data_oe;

  modport master (
    input  s_valid, s_data, s_last, near_full,
    output s_ready, oe_req, spi_cs_n, spi_sck, spi_data_o, spi_data_oe
  );

  modport slave (
    output s_valid, s_data, s_last, near_full,
    input  s_ready, oe_req, spi_cs_n, spi_sck, spi_data_o, spi_data_oe
  );

endinterface

// File: rtl/spi_host_wr_master_sync_2ff.sv
// rtl/spi_host_wr_master_sync_2ff.sv - two-flop single-bit synchroniser with selectable reset value
module spi_host_wr_master_sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= {2{RST_VAL}};
    end else begin
      ff <= {ff[0], d};
    end
  end

  assign q = ff[1];

endmodule

// File: rtl/spi_host_wr_master.sv
// rtl/spi_host_wr_master.sv - bursts local stream words onto the shared parallel SPI bus
module spi_host_wr_master
  import spi_host_wr_master_pkg::*;
#(
  parameter int SPI_WIDTH = SPI_WIDTH_DEF,
  parameter int CLK_DIV   = 2,
  parameter int BURST_MAX = 16,
  parameter int TURN_CYC  = 2,
  localparam int BW_W     = cnt_width(BURST_MAX)
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_host_wr_master_if.master  bus,
  output logic                  busy,
  output logic [BW_W-1:0]       burst_words
);

  localparam int CNT_MAX = (CLK_DIV > TURN_CYC) ? CLK_DIV : TURN_CYC;
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);
  localparam logic [BW_W-1:0]  BW_MAX    = BW_W'(BURST_MAX);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 nf_s;
  logic                 last_q, last_nxt;
  logic                 oe_q, oe_nxt;
  logic                 cs_n_q, cs_n_nxt;
  logic                 sck_q, sck_nxt;
  logic                 doe_q, doe_nxt;
  logic [SPI_WIDTH-1:0] data_q, data_nxt;
  logic [BW_W-1:0]      bw_q, bw_nxt;
  logic                 s_ready_q;
  logic                 busy_q;

  spi_host_wr_master_sync_2ff #(.RST_VAL(1'b1)) u_nf_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.near_full),
    .q   (nf_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      last_q    <= 1'b0;
      oe_q      <= 1'b0;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      doe_q     <= 1'b0;
      data_q    <= '0;
      bw_q      <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last_q    <= last_nxt;
      oe_q      <= oe_nxt;
      cs_n_q    <= cs_n_nxt;
      sck_q     <= sck_nxt;
      doe_q     <= doe_nxt;
      data_q    <= data_nxt;
      bw_q      <= bw_nxt;
      s_ready_q <= (state_nxt == ST_LOAD);
      busy_q    <= (state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    last_nxt  = last_q;
    oe_nxt    = oe_q;
    cs_n_nxt  = cs_n_q;
    sck_nxt   = sck_q;
    doe_nxt   = doe_q;
    data_nxt  = data_q;
    bw_nxt    = bw_q;
    unique case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (bus.s_valid && !nf_s) begin
          oe_nxt    = 1'b1;
          bw_nxt    = '0;
          state_nxt = ST_CLAIM;
        end
      end
      ST_CLAIM: begin
        if (cnt == TURN_LAST) begin
          cnt_nxt   = '0;
          doe_nxt   = 1'b1;
          cs_n_nxt  = 1'b0;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // A stall here holds cs_n low; near_full is deliberately ignored.
        cnt_nxt = '0;
        if (bus.s_valid) begin
          data_nxt  = bus.s_data;
          last_nxt  = bus.s_last;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt == DIV_LAST) begin
          cnt_nxt   = '0;
          sck_nxt   = 1'b1;
          state_nxt = ST_HIGH;
          if (bw_q != BW_MAX) begin
            bw_nxt = bw_q + 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (cnt == DIV_LAST) begin
          cnt_nxt = '0;
          sck_nxt = 1'b0;
          if (last_q || (bw_q == BW_MAX) || nf_s) begin
            cs_n_nxt  = 1'b1;
            state_nxt = ST_END;
          end else begin
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_END: begin
        if (cnt == DIV_LAST) begin
          cnt_nxt   = '0;
          doe_nxt   = 1'b0;
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (cnt == TURN_LAST) begin
          cnt_nxt   = '0;
          oe_nxt    = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.s_ready     = s_ready_q;
  assign bus.oe_req      = oe_q;
  assign bus.spi_cs_n    = cs_n_q;
  assign bus.spi_sck     = sck_q;
  assign bus.spi_data_o  = data_q;
  assign bus.spi_data_oe = doe_q;
  assign busy            = busy_q;
  assign burst_words     = bw_q;

endmodule
